// File: rtl/imem_loadable.sv
// imem_loadable: run-time loadable instruction memory with registered fetch port, stall hold,
// fetch error flagging and load overflow detection.
module imem_loadable #(
    parameter int          ADDR_W = 32,
    parameter int          DEPTH  = 256,
    parameter logic [31:0] NOP    = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_load_start,
    input  logic                       i_load_valid,
    input  logic [31:0]                i_load_data,
    input  logic                       i_load_last,
    output logic                       o_load_ready,
    output logic [$clog2(DEPTH):0]     o_load_count,
    output logic                       o_load_ovf,
    output logic                       o_imem_ready,
    input  logic                       i_fetch_valid,
    input  logic [ADDR_W-1:0]          i_fetch_addr,
    input  logic                       i_stall,
    output logic [31:0]                o_inst,
    output logic                       o_inst_valid,
    output logic                       o_addr_err
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {S_CLEAR, S_RUN, S_LOAD} state_t;

    state_t             r_state, w_next;
    logic [IDX_W-1:0]   r_clr_ptr;
    logic [IDX_W:0]     r_load_count;
    logic               r_load_ovf;
    logic [31:0]        r_inst;
    logic               r_inst_valid, r_addr_err;
    logic [31:0]        r_mem [DEPTH];
    logic               w_we, w_accept, w_full, w_start, w_fetch, w_bad;
    logic [IDX_W-1:0]   w_waddr, w_idx;
    logic [31:0]        w_wdata;

    assign w_accept = (r_state == S_LOAD) && i_load_valid;
    assign w_full   = r_load_count == (IDX_W+1)'(DEPTH);
    assign w_start  = (r_state == S_RUN) && i_load_start;
    // a fetch colliding with load_start is dropped so the load owns the next cycle
    assign w_fetch  = (r_state == S_RUN) && i_fetch_valid && !i_stall && !i_load_start;
    assign w_idx    = i_fetch_addr[IDX_W+1:2];
    assign w_bad    = (|i_fetch_addr[1:0]) || (|i_fetch_addr[ADDR_W-1:IDX_W+2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_CLEAR;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CLEAR: if (r_clr_ptr == IDX_W'(DEPTH-1)) w_next = S_RUN;
            S_RUN:   if (i_load_start) w_next = S_LOAD;
            S_LOAD:  if (w_accept && i_load_last) w_next = S_RUN;
            default: w_next = S_CLEAR;
        endcase
    end

    always_comb begin
        o_load_ready = r_state == S_LOAD;
        o_imem_ready = r_state == S_RUN;
        w_we         = (r_state == S_CLEAR) || (w_accept && !w_full);
        w_waddr      = (r_state == S_CLEAR) ? r_clr_ptr : r_load_count[IDX_W-1:0];
        w_wdata      = (r_state == S_CLEAR) ? NOP : i_load_data;
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_ptr    <= '0;
            r_load_count <= '0;
            r_load_ovf   <= 1'b0;
        end else begin
            if (r_state == S_CLEAR) r_clr_ptr <= r_clr_ptr + IDX_W'(1);
            if (w_start) begin
                r_load_count <= '0;
                r_load_ovf   <= 1'b0;
            end else if (w_accept) begin
                if (w_full) r_load_ovf <= 1'b1;
                else        r_load_count <= r_load_count + (IDX_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst       <= NOP;
            r_inst_valid <= 1'b0;
            r_addr_err   <= 1'b0;
        end else if (r_state != S_RUN || i_load_start) begin
            r_inst_valid <= 1'b0;
            r_addr_err   <= 1'b0;
        end else if (!i_stall) begin
            r_inst_valid <= w_fetch;
            r_addr_err   <= w_fetch && w_bad;
            if (w_fetch) r_inst <= w_bad ? NOP : r_mem[w_idx];
        end
    end

    assign o_load_count = r_load_count;
    assign o_load_ovf   = r_load_ovf;
    assign o_inst       = r_inst;
    assign o_inst_valid = r_inst_valid;
    assign o_addr_err   = r_addr_err;
endmodule

// File: tb/tb_imem_loadable.sv
// tb_imem_loadable: directed checks of clear, load, fetch, stall, error and overflow behaviour
// on a 16-word instance.
module tb_imem_loadable;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_ready, load_ovf, imem_ready;
    logic [4:0]  load_count;
    logic        fetch_valid = 1'b0, stall = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic [31:0] inst;
    logic        inst_valid, addr_err;
    int          checks = 0, errors = 0;

    imem_loadable #(.ADDR_W(32), .DEPTH(DEPTH), .NOP(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_load_start(load_start), .i_load_valid(load_valid), .i_load_data(load_data),
        .i_load_last(load_last), .o_load_ready(load_ready), .o_load_count(load_count),
        .o_load_ovf(load_ovf), .o_imem_ready(imem_ready),
        .i_fetch_valid(fetch_valid), .i_fetch_addr(fetch_addr), .i_stall(stall),
        .o_inst(inst), .o_inst_valid(inst_valid), .o_addr_err(addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_valid = 1'b1;
        fetch_addr  = a;
        tick();
        fetch_valid = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_inst"}, inst, 32'h0);
        chk({tag, "_ival"}, {31'b0, inst_valid}, 32'h0);
        chk({tag, "_err"}, {31'b0, addr_err}, 32'h0);
        chk({tag, "_lrdy"}, {31'b0, load_ready}, 32'h0);
        chk({tag, "_irdy"}, {31'b0, imem_ready}, 32'h0);
        chk({tag, "_cnt"}, {27'b0, load_count}, 32'h0);
        chk({tag, "_ovf"}, {31'b0, load_ovf}, 32'h0);
    endtask

    task automatic run_clear(input string tag);
        repeat (DEPTH - 1) tick();
        chk({tag, "_busy"}, {31'b0, imem_ready}, 32'h0);
        tick();
        chk({tag, "_ready"}, {31'b0, imem_ready}, 32'h1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst0");
        tick();
        tick();
        rst_n = 1'b1;
        run_clear("clr0");
        for (int a = 0; a < DEPTH; a++) begin
            fetch(32'(a * 4));
            chk($sformatf("clr_fetch%0d", a), inst, 32'h0);
            chk($sformatf("clr_val%0d", a), {31'b0, inst_valid}, 32'h1);
            chk($sformatf("clr_err%0d", a), {31'b0, addr_err}, 32'h0);
        end

        // T2 load and run
        start_load();
        chk("t2_lrdy", {31'b0, load_ready}, 32'h1);
        chk("t2_irdy0", {31'b0, imem_ready}, 32'h0);
        load_word(32'h08000003, 1'b0);
        load_word(32'h0800000a, 1'b0);
        load_word(32'h3c083000, 1'b0);
        load_word(32'h1000ffff, 1'b1);
        chk("t2_cnt", {27'b0, load_count}, 32'd4);
        chk("t2_irdy", {31'b0, imem_ready}, 32'h1);
        chk("t2_lrdy_off", {31'b0, load_ready}, 32'h0);
        fetch(32'h8);
        chk("t2_f8", inst, 32'h3c083000);
        chk("t2_f8v", {31'b0, inst_valid}, 32'h1);
        fetch(32'h10);
        chk("t2_f10", inst, 32'h0);
        tick();
        chk("t2_idle_v", {31'b0, inst_valid}, 32'h0);
        chk("t2_idle_hold", inst, 32'h0);

        // T3 stall
        fetch(32'h0);
        chk("t3_f0", inst, 32'h08000003);
        fetch_valid = 1'b1;
        fetch_addr  = 32'h4;
        stall       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t3_hold%0d", i), inst, 32'h08000003);
            chk($sformatf("t3_holdv%0d", i), {31'b0, inst_valid}, 32'h1);
        end
        stall = 1'b0;
        tick();
        fetch_valid = 1'b0;
        chk("t3_f4", inst, 32'h0800000a);
        tick();
        chk("t3_idle_v", {31'b0, inst_valid}, 32'h0);
        chk("t3_idle_hold", inst, 32'h0800000a);

        // T4 errors
        fetch(32'h6);
        chk("t4_mis_err", {31'b0, addr_err}, 32'h1);
        chk("t4_mis_inst", inst, 32'h0);
        chk("t4_mis_v", {31'b0, inst_valid}, 32'h1);
        fetch(32'h40);
        chk("t4_oor_err", {31'b0, addr_err}, 32'h1);
        fetch(32'hFFFFFFFC);
        chk("t4_top_err", {31'b0, addr_err}, 32'h1);
        stall = 1'b1;
        tick();
        chk("t4_stall_err", {31'b0, addr_err}, 32'h1);
        stall = 1'b0;
        fetch(32'hC);
        chk("t4_ok_err", {31'b0, addr_err}, 32'h0);
        chk("t4_ok_inst", inst, 32'h1000ffff);

        // T5 overflow
        start_load();
        for (int i = 0; i < 18; i++) begin
            load_word(32'hA0000000 + 32'(i), i == 17);
            if (i == 15) chk("t5_ovf_early", {31'b0, load_ovf}, 32'h0);
        end
        chk("t5_cnt", {27'b0, load_count}, 32'd16);
        chk("t5_ovf", {31'b0, load_ovf}, 32'h1);
        chk("t5_irdy", {31'b0, imem_ready}, 32'h1);
        fetch(32'h3C);
        chk("t5_f3c", inst, 32'hA000000F);
        fetch(32'h0);
        chk("t5_f0", inst, 32'hA0000000);
        start_load();
        chk("t5_ovf_clr", {31'b0, load_ovf}, 32'h0);
        chk("t5_cnt_clr", {27'b0, load_count}, 32'h0);
        load_word(32'h12345678, 1'b1);
        chk("t5_cnt1", {27'b0, load_count}, 32'd1);
        fetch(32'h0);
        chk("t5_new0", inst, 32'h12345678);
        fetch(32'h4);
        chk("t5_nocl", inst, 32'hA0000001);

        // T6 collision
        load_start  = 1'b1;
        fetch_valid = 1'b1;
        fetch_addr  = 32'h0;
        tick();
        load_start = 1'b0;
        chk("t6_v", {31'b0, inst_valid}, 32'h0);
        chk("t6_lrdy", {31'b0, load_ready}, 32'h1);
        chk("t6_irdy", {31'b0, imem_ready}, 32'h0);
        tick();
        fetch_valid = 1'b0;
        chk("t6_load_v", {31'b0, inst_valid}, 32'h0);
        chk("t6_inst_hold", inst, 32'hA0000001);

        // T1 reset mid-load, then full clear
        load_word(32'hDEADBEEF, 1'b0);
        chk("t1_cnt_pre", {27'b0, load_count}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t1");
        rst_n = 1'b1;
        run_clear("t1_clr");
        fetch(32'h0);
        chk("t1_f0", inst, 32'h0);
        chk("t1_f0v", {31'b0, inst_valid}, 32'h1);
        fetch(32'h3C);
        chk("t1_f3c", inst, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
